// File: rtl/ncl_phase_sequencer.sv
// ncl_phase_sequencer
//   Clocked phase controller for a dual-rail NULL-convention combinational
//   array. Drives the array with high-NULL, low-NULL and DATA wavefronts,
//   watches the synchronized array outputs for completion, captures each
//   DATA result into the next input word, and flags a stalled array.
//
// Optional feature macro: NCL_SEQ_CHECK_EN
//   Defined:   each capture is checked against previous result + 1; a
//              mismatch sets the sticky check_err (first capture after a
//              seed load is not checked).
//   Undefined: no check logic, check_err is tied 0.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   run_en         level, keep iterating while high
//   seed_load      in IDLE, load seed_in into the working word
//   seed_in        dual-rail seed word
//   rails_out      registered dual-rail drive into the array
//   rails_in       array outputs, asynchronous to clk
//   result         decoded single-rail value of the last captured word
//   result_valid   one-cycle pulse per capture
//   phase          IDLE=0 HNULL=1 LNULL=2 DATA=3 CAPTURE=4
//   iter_count     completed captures, wrapping
//   timeout_err    sticky watchdog flag
//   check_err      sticky increment-check flag (0 without the macro)

module ncl_phase_sequencer #(
   parameter int unsigned WIDTH       = 24,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 1023
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run_en,
   input  logic                 seed_load,
   input  logic [2*WIDTH-1:0]   seed_in,
   output logic [2*WIDTH-1:0]   rails_out,
   input  logic [2*WIDTH-1:0]   rails_in,
   output logic [WIDTH-1:0]     result,
   output logic                 result_valid,
   output logic [2:0]           phase,
   output logic [15:0]          iter_count,
   output logic                 timeout_err,
   output logic                 check_err
);

   localparam int unsigned RW    = 2 * WIDTH;
   localparam int unsigned NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int unsigned WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HNULL   = 3'd1;
   localparam logic [2:0] ST_LNULL   = 3'd2;
   localparam logic [2:0] ST_DATA    = 3'd3;
   localparam logic [2:0] ST_CAPTURE = 3'd4;

   // Single-rail value of a dual-rail word: the upper rail of each pair.
   function automatic logic [WIDTH-1:0] decode(input logic [RW-1:0] w);
      logic [WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < WIDTH; i++) v[i] = w[2*i+1];
      return v;
   endfunction

   // Dual-rail encoding of a single-rail value.
   function automatic logic [RW-1:0] encode(input logic [WIDTH-1:0] v);
      logic [RW-1:0] w;
      w = '0;
      for (int i = 0; i < WIDTH; i++) w[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
      return w;
   endfunction

   localparam logic [RW-1:0] WORK_RST = encode(WIDTH'(1));

   // ---------------------------------------------------------------
   // Input synchronizer
   // ---------------------------------------------------------------
   logic [RW-1:0] sync_q [NSYNC];
   logic [RW-1:0] sync_d [NSYNC];
   logic [RW-1:0] s;

   always_comb begin
      sync_d[0] = rails_in;
      for (int i = 1; i < NSYNC; i++) sync_d[i] = sync_q[i-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSYNC; i++) sync_q[i] <= '1;
      end else begin
         for (int i = 0; i < NSYNC; i++) sync_q[i] <= sync_d[i];
      end
   end

   assign s = sync_q[NSYNC-1];

   // ---------------------------------------------------------------
   // Completion detectors with two-cycle stability filter
   // ---------------------------------------------------------------
   logic       dr_c, hn_c, ln_c;
   logic [2:0] det_q, det_d;
   logic       dr_seen_c, hn_seen_c, ln_seen_c;

   always_comb begin
      dr_c = 1'b1;
      for (int i = 0; i < WIDTH; i++) dr_c = dr_c & (s[2*i+1] ^ s[2*i]);
   end

   assign hn_c  = &s;
   assign ln_c  = ~|s;
   assign det_d = {dr_c, hn_c, ln_c};

   // A detector is trusted only when it holds on two consecutive cycles.
   assign dr_seen_c = dr_c & det_q[2];
   assign hn_seen_c = hn_c & det_q[1];
   assign ln_seen_c = ln_c & det_q[0];

   // ---------------------------------------------------------------
   // Phase FSM, watchdog and capture datapath
   // ---------------------------------------------------------------
   logic [2:0]       state_q, state_d;
   logic [RW-1:0]    rails_out_q, rails_out_d;
   logic [RW-1:0]    work_q, work_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             result_valid_q, result_valid_d;
   logic [15:0]      iter_q, iter_d;
   logic             timeout_err_q, timeout_err_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             wd_expired_c;
   logic             cap_c;
   logic             seed_c;

   // Last allowed cycle in a phase; the state is left on that edge.
   assign wd_expired_c = (wd_q == WD_W'(TIMEOUT - 1));
   assign cap_c        = (state_q == ST_DATA) && dr_seen_c;
   assign seed_c       = (state_q == ST_IDLE) && seed_load;

   always_comb begin
      state_d        = state_q;
      rails_out_d    = rails_out_q;
      work_d         = work_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      iter_d         = iter_q;
      timeout_err_d  = timeout_err_q;
      wd_d           = '0;

      case (state_q)
         ST_IDLE: begin
            rails_out_d = '1;
            if (seed_load) begin
               work_d = seed_in;
            end else if (run_en) begin
               state_d       = ST_HNULL;
               timeout_err_d = 1'b0;
            end
         end
         ST_HNULL: begin
            rails_out_d = '1;
            if (hn_seen_c) begin
               state_d = ST_LNULL;
            end else if (wd_expired_c) begin
               state_d       = ST_IDLE;
               timeout_err_d = 1'b1;
            end
         end
         ST_LNULL: begin
            rails_out_d = '0;
            if (ln_seen_c) begin
               state_d = ST_DATA;
            end else if (wd_expired_c) begin
               state_d       = ST_IDLE;
               timeout_err_d = 1'b1;
            end
         end
         ST_DATA: begin
            rails_out_d = work_q;
            if (dr_seen_c) begin
               state_d        = ST_CAPTURE;
               work_d         = s;
               result_d       = decode(s);
               result_valid_d = 1'b1;
               iter_d         = iter_q + 16'd1;
            end else if (wd_expired_c) begin
               state_d       = ST_IDLE;
               timeout_err_d = 1'b1;
            end
         end
         ST_CAPTURE: begin
            // Hold the DATA drive so the spacer starts with HNULL proper.
            state_d = run_en ? ST_HNULL : ST_IDLE;
         end
         default: begin
            state_d     = ST_IDLE;
            rails_out_d = '1;
         end
      endcase

      // Watchdog runs only while waiting on the array; clears on entry.
      if ((state_d == state_q) &&
          ((state_q == ST_HNULL) || (state_q == ST_LNULL) || (state_q == ST_DATA))) begin
         wd_d = wd_q + WD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         rails_out_q    <= '1;
         work_q         <= WORK_RST;
         result_q       <= WIDTH'(1);
         result_valid_q <= 1'b0;
         iter_q         <= '0;
         timeout_err_q  <= 1'b0;
         wd_q           <= '0;
         det_q          <= '0;
      end else begin
         state_q        <= state_d;
         rails_out_q    <= rails_out_d;
         work_q         <= work_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         iter_q         <= iter_d;
         timeout_err_q  <= timeout_err_d;
         wd_q           <= wd_d;
         det_q          <= det_d;
      end
   end

   // ---------------------------------------------------------------
   // Optional increment check
   // ---------------------------------------------------------------
`ifdef NCL_SEQ_CHECK_EN
   logic check_err_q, check_err_d;
   logic first_q, first_d;

   always_comb begin
      check_err_d = check_err_q;
      first_d     = first_q;
      if (seed_c) begin
         first_d = 1'b1;
      end else if (cap_c) begin
         first_d = 1'b0;
         if (!first_q && (decode(s) != (result_q + WIDTH'(1)))) check_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         check_err_q <= 1'b0;
         first_q     <= 1'b0;
      end else begin
         check_err_q <= check_err_d;
         first_q     <= first_d;
      end
   end

   assign check_err = check_err_q;
`else
   logic unused_c;
   assign unused_c  = &{1'b0, cap_c, seed_c};
   assign check_err = 1'b0;
`endif

   assign rails_out    = rails_out_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign phase        = state_q;
   assign iter_count   = iter_q;
   assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_ncl_phase_sequencer.sv
// Directed bench for ncl_phase_sequencer: a delayed incrementer model (and
// stuck / directly driven variants) closes the loop around the sequencer.
module tb_ncl_phase_sequencer;

   localparam int W  = 24;
   localparam int RW = 48;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          run_en;
   logic          seed_load;
   logic [RW-1:0] seed_in;
   logic [RW-1:0] rails_out;
   logic [RW-1:0] rails_in;
   logic [W-1:0]  result;
   logic          result_valid;
   logic [2:0]    phase;
   logic [15:0]   iter_count;
   logic          timeout_err;
   logic          check_err;

   int total = 0;
   int bad   = 0;

   // 0 incrementer, 1 stuck high-NULL, 2 direct drive, 3 add-two model
   int            mode = 0;
   logic [RW-1:0] direct_rails = '0;
   logic [RW-1:0] dly [5];

   always #5 clk = ~clk;

   ncl_phase_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run_en       (run_en),
      .seed_load    (seed_load),
      .seed_in      (seed_in),
      .rails_out    (rails_out),
      .rails_in     (rails_in),
      .result       (result),
      .result_valid (result_valid),
      .phase        (phase),
      .iter_count   (iter_count),
      .timeout_err  (timeout_err),
      .check_err    (check_err)
   );

   function automatic logic [RW-1:0] enc(input logic [W-1:0] v);
      logic [RW-1:0] w;
      w = '0;
      for (int i = 0; i < W; i++) w[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
      return w;
   endfunction

   function automatic logic [W-1:0] dec(input logic [RW-1:0] w);
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < W; i++) v[i] = (w[2*i +: 2] == 2'b10);
      return v;
   endfunction

   // Array model: spacers pass through, data words come out as value+step.
   function automatic logic [RW-1:0] arr(input logic [RW-1:0] w, input int step);
      if ((&w) || (~|w)) return w;
      return enc(dec(w) + W'(step));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) dly[i] <= '1;
      end else begin
         dly[0] <= arr(rails_out, (mode == 3) ? 2 : 1);
         for (int i = 1; i < 5; i++) dly[i] <= dly[i-1];
      end
   end

   assign rails_in = (mode == 1) ? '1 : (mode == 2) ? direct_rails : dly[4];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      cycles(2);
      rst_n = 1'b1;
   endtask

   task automatic wait_phase(input logic [2:0] p, input int budget, input string tag);
      int n;
      n = 0;
      while (phase !== p && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(phase), 64'(p));
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (result_valid !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(result_valid), 64'd1);
   endtask

   logic [47:0]  seq;
   logic [2:0]   last;
   logic [W-1:0] res [3];
   logic [15:0]  itc [3];
   int           at  [3];
   int           nv, n, lcnt;
   logic         saw;

   initial begin
      rst_n     = 1'b0;
      run_en    = 1'b0;
      seed_load = 1'b0;
      seed_in   = '0;
      cycles(2);
      rst_n = 1'b1;
      cycles(10);

      // Reset state
      chk("rst_phase", 64'(phase), 64'd0);
      chk("rst_rails_out", 64'(rails_out), 64'hFFFF_FFFF_FFFF);
      chk("rst_result", 64'(result), 64'd1);
      chk("rst_valid", 64'(result_valid), 64'd0);
      chk("rst_iter", 64'(iter_count), 64'd0);
      chk("rst_timeout", 64'(timeout_err), 64'd0);
      chk("rst_check", 64'(check_err), 64'd0);

      // Free run with a 5-cycle incrementer
      run_en = 1'b1;
      last = 3'd0; seq = '0; nv = 0; n = 0;
      while (nv < 3 && n < 300) begin
         @(negedge clk);
         n++;
         if (phase !== last) begin
            seq  = {seq[43:0], 1'b0, phase};
            last = phase;
         end
         if (result_valid === 1'b1) begin
            res[nv] = result;
            itc[nv] = iter_count;
            at[nv]  = n;
            nv++;
         end
      end
      chk("run_valid_count", 64'(nv), 64'd3);
      chk("run_result0", 64'(res[0]), 64'd2);
      chk("run_result1", 64'(res[1]), 64'd3);
      chk("run_result2", 64'(res[2]), 64'd4);
      chk("run_iter0", 64'(itc[0]), 64'd1);
      chk("run_iter1", 64'(itc[1]), 64'd2);
      chk("run_iter2", 64'(itc[2]), 64'd3);
      chk("run_phase_seq", 64'(seq), 64'h1234_1234_1234);
      chk("run_period_a", 64'(at[1] - at[0]), 64'd31);
      chk("run_period_b", 64'(at[2] - at[1]), 64'd31);

      // Drop run_en during DATA: the iteration still completes
      wait_phase(3'd3, 60, "reach_data");
      run_en = 1'b0;
      nv = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (result_valid === 1'b1) nv++;
      end
      chk("drop_valid_count", 64'(nv), 64'd1);
      chk("drop_phase", 64'(phase), 64'd0);
      chk("drop_rails_out", 64'(rails_out), 64'hFFFF_FFFF_FFFF);
      chk("drop_iter", 64'(iter_count), 64'd4);

      // Asynchronous reset mid-iteration
      run_en = 1'b1;
      cycles(15);
      rst_n = 1'b0;
      #1;
      chk("areset_phase", 64'(phase), 64'd0);
      chk("areset_rails_out", 64'(rails_out), 64'hFFFF_FFFF_FFFF);
      chk("areset_result", 64'(result), 64'd1);
      chk("areset_iter", 64'(iter_count), 64'd0);
      run_en = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      cycles(10);

      // Seed load has priority over run_en, then run from 0xFFFFFF
      seed_in   = enc(24'hFF_FFFF);
      seed_load = 1'b1;
      run_en    = 1'b1;
      @(negedge clk);
      chk("seed_priority_phase", 64'(phase), 64'd0);
      seed_load = 1'b0;
      wait_valid(200, "seed_valid_seen");
      chk("seed_result", 64'(result), 64'd0);
      chk("seed_iter", 64'(iter_count), 64'd1);

      // Seed load outside IDLE is ignored
      wait_phase(3'd1, 10, "reach_hnull");
      seed_in   = enc(24'h00_0100);
      seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      wait_valid(200, "ignored_seed_valid_seen");
      chk("ignored_seed_result", 64'(result), 64'd1);
      chk("ignored_seed_iter", 64'(iter_count), 64'd2);
      run_en = 1'b0;
      wait_phase(3'd0, 100, "seed_back_idle");

      // Stuck array: watchdog fires after TIMEOUT cycles in LNULL
      do_reset();
      mode = 1;
      cycles(10);
      run_en = 1'b1;
      wait_phase(3'd2, 50, "stuck_reach_lnull");
      run_en = 1'b0;
      lcnt = 0; nv = 0; n = 0;
      while (phase !== 3'd0 && n < 1200) begin
         if (phase === 3'd2) lcnt++;
         if (result_valid === 1'b1) nv++;
         @(negedge clk);
         n++;
      end
      chk("tmo_lnull_cycles", 64'(lcnt), 64'd1023);
      chk("tmo_valid_count", 64'(nv), 64'd0);
      chk("tmo_flag", 64'(timeout_err), 64'd1);
      chk("tmo_phase", 64'(phase), 64'd0);
      cycles(3);
      chk("tmo_rails_out", 64'(rails_out), 64'hFFFF_FFFF_FFFF);
      chk("tmo_flag_sticky", 64'(timeout_err), 64'd1);
      mode = 0;
      cycles(8);
      run_en = 1'b1;
      @(negedge clk);
      chk("tmo_clear_phase", 64'(phase), 64'd1);
      chk("tmo_clear_flag", 64'(timeout_err), 64'd0);
      run_en = 1'b0;
      wait_phase(3'd0, 100, "tmo_back_idle");

      // One-cycle hn glitch in HNULL does not advance; two cycles do
      do_reset();
      mode = 2;
      direct_rails = '0;
      cycles(10);
      run_en = 1'b1;
      @(negedge clk);
      run_en = 1'b0;
      chk("glitch_in_hnull", 64'(phase), 64'd1);
      direct_rails = '1;
      @(negedge clk);
      direct_rails = '0;
      cycles(8);
      chk("glitch_no_advance", 64'(phase), 64'd1);
      direct_rails = '1;
      cycles(2);
      direct_rails = '0;
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (phase === 3'd2) saw = 1'b1;
      end
      chk("glitch_two_advance", 64'(saw), 64'd1);
      do_reset();
      mode = 0;
      cycles(10);

`ifdef NCL_SEQ_CHECK_EN
      // Add-two array trips the increment check on the second capture
      mode = 3;
      cycles(8);
      seed_in   = enc(24'd5);
      seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      run_en    = 1'b1;
      wait_valid(200, "chk_valid1_seen");
      chk("chk_result1", 64'(result), 64'd7);
      chk("chk_err_after1", 64'(check_err), 64'd0);
      wait_valid(200, "chk_valid2_seen");
      chk("chk_result2", 64'(result), 64'd9);
      chk("chk_err_after2", 64'(check_err), 64'd1);
      wait_valid(200, "chk_valid3_seen");
      chk("chk_err_sticky", 64'(check_err), 64'd1);
      run_en = 1'b0;
      wait_phase(3'd0, 100, "chk_back_idle");
      mode = 0;
`else
      chk("check_err_tied", 64'(check_err), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
